// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Packs a RISC-V style field bundle (fmt, opcode, funct3, funct7, rd, rs1,
// rs2, imm) into a 32-bit instruction word. Each result is tagged with the
// address taken from an internal program counter and with a range-error flag.
// Results are queued in a 2-entry FIFO and leave through a valid/ready
// output handshake.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous reset, active high
//   in_valid     : input bundle valid
//   in_ready     : encoder can accept a bundle (FIFO count < 2)
//   fmt          : 0=R 1=I 2=S 3=B 4=U 5=J, 6..7 invalid
//   opcode, funct3, funct7, rd, rs1, rs2, imm : instruction fields
//   pc_load      : load the address counter
//   pc_load_val  : value loaded into the address counter
//   out_valid    : head of FIFO holds a result
//   out_ready    : consumer takes the head result
//   out_inst     : encoded instruction word (0 when out_valid=0)
//   out_addr     : address of that word (0 when out_valid=0)
//   out_err      : range-error flag of that word (0 when out_valid=0)
//   err_cnt      : saturating count of accepted bundles flagged in error
// -----------------------------------------------------------------------------
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  // FIFO storage and bookkeeping
  logic [31:0] r_instMem [2];
  logic [31:0] r_addrMem [2];
  logic        r_errMem  [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;

  // Held low through reset and until the first clock edge afterwards,
  // so in_ready only rises once the block is out of reset.
  logic        r_started;

  logic [31:0] r_pc;
  logic [7:0]  r_errCnt;

  logic        w_push;
  logic        w_pop;
  logic [31:0] w_inst;
  logic        w_err;
  logic [31:0] w_addr;
  logic        w_immOk11;
  logic        w_immOk12;
  logic        w_immOk20;
  fmt_e        w_fmt;

  assign w_fmt = fmt_e'(fmt);

  // An immediate fits a sign-extended field when all bits above the field's
  // sign bit match it, i.e. the upper slice is all ones or all zeros.
  assign w_immOk11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_immOk12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign w_immOk20 = (&imm[31:20]) | ~(|imm[31:20]);

  // Field packing per format. Out-of-range immediates are still packed
  // (truncated) and only flagged through w_err.
  always_comb begin
    w_inst = 32'h0;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: begin
        w_inst = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        w_inst = {imm[11:0], rs1, funct3, rd, opcode};
        w_err  = ~w_immOk11;
      end
      FMT_S: begin
        w_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_err  = ~w_immOk11;
      end
      FMT_B: begin
        w_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_err  = ~w_immOk12 | imm[0];
      end
      FMT_U: begin
        w_inst = {imm[31:12], rd, opcode};
        w_err  = |imm[11:0];
      end
      FMT_J: begin
        w_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_err  = ~w_immOk20 | imm[0];
      end
      default: begin
        w_inst = 32'h0;
        w_err  = 1'b1;
      end
    endcase
  end

  // Handshake decode. in_ready depends only on registered state so it never
  // combinationally follows out_ready.
  assign in_ready  = r_started && (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // A load in the same cycle as an accept gives the bundle the loaded address.
  assign w_addr = pc_load ? pc_load_val : r_pc;

  // FIFO write side, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instMem[0] <= 32'h0;
      r_instMem[1] <= 32'h0;
      r_addrMem[0] <= 32'h0;
      r_addrMem[1] <= 32'h0;
      r_errMem[0]  <= 1'b0;
      r_errMem[1]  <= 1'b0;
      r_wrPtr      <= 1'b0;
      r_rdPtr      <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      if (w_push) begin
        r_instMem[r_wrPtr] <= w_inst;
        r_addrMem[r_wrPtr] <= w_addr;
        r_errMem[r_wrPtr]  <= w_err;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Address counter; wraps naturally modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= 32'h0;
    end else if (w_push) begin
      r_pc <= w_addr + 32'd4;
    end else if (pc_load) begin
      r_pc <= pc_load_val;
    end
  end

  // Error counter sticks at its maximum instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errCnt <= 8'h0;
    end else if (w_push && w_err && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Head-of-FIFO data, forced to zero whenever nothing is valid
  assign out_inst = out_valid ? r_instMem[r_rdPtr] : 32'h0;
  assign out_addr = out_valid ? r_addrMem[r_rdPtr] : 32'h0;
  assign out_err  = out_valid ? r_errMem[r_rdPtr]  : 1'b0;
  assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//
// Self-checking bench for inst_encoder. A reference model (queue of expected
// results, address counter, error counter) is advanced alongside the DUT on
// every clock; each scenario task compares DUT outputs to literal values and
// to that model.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t      mQ[$];
  logic [31:0] mPc;
  int          mErrCnt;
  bit          mStarted;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference encoding built from shifted/masked fields; range errors are
  // judged on the signed value of imm rather than on bit patterns.
  function automatic void modelEncode(input logic [31:0] f, input logic [31:0] op,
                                      input logic [31:0] f3, input logic [31:0] f7,
                                      input logic [31:0] d, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] im,
                                      output logic [31:0] inst, output logic err);
    int s;
    s = im;
    inst = 0;
    err = 0;
    case (f)
      0: inst = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      1: begin
        inst = ((im & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
        err = (s < -2048) || (s > 2047);
      end
      2: begin
        inst = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
             | ((im & 32'h1F) << 7) | op;
        err = (s < -2048) || (s > 2047);
      end
      3: begin
        inst = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
             | (s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
             | (((im >> 11) & 1) << 7) | op;
        err = (s < -4096) || (s > 4095) || (im % 2 != 0);
      end
      4: begin
        inst = (im & 32'hFFFFF000) | (d << 7) | op;
        err = (im % 4096) != 0;
      end
      5: begin
        inst = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
             | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
        err = (s < -1048576) || (s > 1048575) || (im % 2 != 0);
      end
      default: begin
        inst = 0;
        err = 1;
      end
    endcase
  endfunction

  task automatic modelReset();
    mQ.delete();
    mPc = 0;
    mErrCnt = 0;
    mStarted = 0;
  endtask

  // Advance model and DUT by one clock, leaving time at posedge+1.
  task automatic tick();
    bit acc;
    bit pop;
    entry_t e;
    logic [31:0] a;
    acc = in_valid && mStarted && (mQ.size() < 2);
    pop = (mQ.size() > 0) && out_ready;
    if (pop) void'(mQ.pop_front());
    if (acc) begin
      modelEncode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, e.inst, e.err);
      a = pc_load ? pc_load_val : mPc;
      e.addr = a;
      mQ.push_back(e);
      mPc = a + 4;
      if (e.err && mErrCnt < 255) mErrCnt++;
    end else if (pc_load) begin
      mPc = pc_load_val;
    end
    @(posedge clk);
    #1;
    if (!reset) mStarted = 1;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 0; pc_load = 0; pc_load_val = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_inst !== 32'h0 || out_addr !== 32'h0 || out_err !== 1'b0)
      $display("[TB] FAIL reset_data: got %h/%h/%b expected 0/0/0", out_inst, out_addr, out_err); else passes++;
    checks++; if (err_cnt !== 8'h0) $display("[TB] FAIL reset_err_cnt: got %h expected 00", err_cnt); else passes++;
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL release_ready_early: got %b expected 0", in_ready); else passes++;
    tick();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_basic();
    applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_inst !== 32'h00500093) $display("[TB] FAIL basic_inst: got %h expected 00500093", out_inst); else passes++;
    checks++; if (out_addr !== 32'h0 || out_err !== 1'b0)
      $display("[TB] FAIL basic_addr_err: got %h/%b expected 0/0", out_addr, out_err); else passes++;
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0)
      $display("[TB] FAIL basic_drain: got %b/%h expected 0/0", out_valid, out_inst); else passes++;
  endtask

  task automatic test_sequence();
    logic [31:0] expInst [3];
    expInst[0] = 32'hFE000EE3; expInst[1] = 32'h123452B7; expInst[2] = 32'h008000EF;
    pc_load = 1; pc_load_val = 32'h100; in_valid = 0; out_ready = 1;
    tick();
    pc_load = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        1: applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        default: applyStimulus(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
      endcase
      in_valid = 1;
      tick();
      checks++; if (out_inst !== expInst[i] || out_addr !== 32'h100 + 4 * i || out_err !== 1'b0)
        $display("[TB] FAIL seq_%0d: got %h@%h err %b expected %h@%h err 0",
                 i, out_inst, out_addr, out_err, expInst[i], 32'h100 + 4 * i);
      else passes++;
    end
    in_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL seq_drain: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_errors();
    out_ready = 1;
    applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    in_valid = 1;
    tick();
    checks++; if (out_inst !== 32'h80000093 || out_err !== 1'b1 || err_cnt !== 8'd1)
      $display("[TB] FAIL err_i: got %h err %b cnt %0d expected 80000093 err 1 cnt 1", out_inst, out_err, err_cnt);
    else passes++;
    applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h3);
    tick();
    checks++; if (out_inst !== 32'h00000163 || out_err !== 1'b1 || err_cnt !== 8'd2)
      $display("[TB] FAIL err_b: got %h err %b cnt %0d expected 00000163 err 1 cnt 2", out_inst, out_err, err_cnt);
    else passes++;
    applyStimulus(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF);
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0 || out_err !== 1'b1)
          $display("[TB] FAIL err_badfmt: got %b/%h/%b expected 1/0/1", out_valid, out_inst, out_err);
        else passes++;
      end
    end
    in_valid = 0;
    tick();
    checks++; if (err_cnt !== 8'hFF) $display("[TB] FAIL err_saturate: got %h expected ff", err_cnt); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL err_drain: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    pc_load = 1; pc_load_val = 32'h200;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    in_valid = 1;
    tick();
    pc_load = 0;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    tick();
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd0);
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_ready: got %b expected 0", in_ready); else passes++;
    tick();
    checks++; if (in_ready !== 1'b0 || out_inst !== 32'h000000B3 || out_addr !== 32'h200)
      $display("[TB] FAIL bp_stable: got rdy %b %h@%h expected rdy 0 000000b3@00000200", in_ready, out_inst, out_addr);
    else passes++;
    out_ready = 1;
    tick();
    checks++; if (out_inst !== 32'h00000133 || out_addr !== 32'h204 || in_ready !== 1'b1)
      $display("[TB] FAIL bp_pop1: got %h@%h rdy %b expected 00000133@00000204 rdy 1", out_inst, out_addr, in_ready);
    else passes++;
    tick();
    in_valid = 0;
    checks++; if (out_inst !== 32'h000001B3 || out_addr !== 32'h208)
      $display("[TB] FAIL bp_third: got %h@%h expected 000001b3@00000208", out_inst, out_addr);
    else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_wrap();
    out_ready = 1; in_valid = 0;
    pc_load = 1; pc_load_val = 32'hFFFFFFFC;
    tick();
    pc_load = 0;
    applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    in_valid = 1;
    tick();
    checks++; if (out_addr !== 32'hFFFFFFFC) $display("[TB] FAIL wrap_first: got %h expected fffffffc", out_addr); else passes++;
    tick();
    in_valid = 0;
    checks++; if (out_addr !== 32'h0) $display("[TB] FAIL wrap_second: got %h expected 00000000", out_addr); else passes++;
    tick();
  endtask

  task automatic test_midreset();
    out_ready = 0;
    applyStimulus(3'd7, 7'h01, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1;
    tick();
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("[TB] FAIL mid_full: got valid %b rdy %b expected 1/0", out_valid, in_ready); else passes++;
    #2;
    reset = 1;
    #1;
    modelReset();
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'h0 || in_ready !== 1'b0 || out_inst !== 32'h0)
      $display("[TB] FAIL mid_reset: got valid %b cnt %h rdy %b inst %h expected 0/00/0/0",
               out_valid, err_cnt, in_ready, out_inst);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_release_empty: got %b expected 0", out_valid); else passes++;
    applyStimulus(3'd0, 7'h33, 3'd1, 7'h20, 5'd7, 5'd8, 5'd9, 32'd0);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_addr !== 32'h0)
      $display("[TB] FAIL mid_first_addr: got valid %b addr %h expected 1/00000000", out_valid, out_addr);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] expInst;
    logic [31:0] expAddr;
    logic        expErr;
    logic        expValid;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      pc_load   = ($urandom_range(0, 19) == 0);
      pc_load_val = $urandom() & 32'hFFFFFFFC;
      fmt = 3'($urandom_range(0, 7));
      opcode = 7'($urandom()); funct3 = 3'($urandom()); funct7 = 7'($urandom());
      rd = 5'($urandom()); rs1 = 5'($urandom()); rs2 = 5'($urandom());
      case ($urandom_range(0, 3))
        0: imm = $urandom_range(0, 16383) - 8192;
        1: imm = $urandom_range(0, 4194303) - 2097152;
        2: imm = $urandom() & 32'hFFFFF000;
        default: imm = $urandom();
      endcase
      expValid = (mQ.size() > 0);
      expInst  = expValid ? mQ[0].inst : 32'h0;
      expAddr  = expValid ? mQ[0].addr : 32'h0;
      expErr   = expValid ? mQ[0].err  : 1'b0;
      checks++; if (in_ready !== (mQ.size() < 2))
        $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", cyc, in_ready, mQ.size() < 2); else passes++;
      checks++; if (out_valid !== expValid)
        $display("[TB] FAIL rnd_valid c%0d: got %b expected %b", cyc, out_valid, expValid); else passes++;
      checks++; if (out_inst !== expInst)
        $display("[TB] FAIL rnd_inst c%0d: got %h expected %h", cyc, out_inst, expInst); else passes++;
      checks++; if (out_addr !== expAddr)
        $display("[TB] FAIL rnd_addr c%0d: got %h expected %h", cyc, out_addr, expAddr); else passes++;
      checks++; if (out_err !== expErr)
        $display("[TB] FAIL rnd_err c%0d: got %b expected %b", cyc, out_err, expErr); else passes++;
      checks++; if (err_cnt !== 8'(mErrCnt))
        $display("[TB] FAIL rnd_err_cnt c%0d: got %0d expected %0d", cyc, err_cnt, mErrCnt); else passes++;
      tick();
    end
    in_valid = 0; pc_load = 0; out_ready = 1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rnd_drain: got %b expected 0", out_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_errors();
    test_back_to_back();
    test_wrap();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
